// File: rtl/axi_full_slave_ram.sv
// AXI4 burst slave backed by a word-addressed RAM.
// The write and read channels each have their own FSM and run concurrently.
module axi_full_slave_ram #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_MEM_DEPTH        = 256
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(C_MEM_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  logic [1:0]       w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len;
  logic [7:0]       w_cnt;
  logic [1:0]       w_burst;
  logic             w_err;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic [1:0]       r_burst;

  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic [IDX_W-1:0] r_idx_next;
  logic             w_fire;
  logic             w_final;
  logic             wlast_bad;
  logic             unused_addr_bits;

  // Only the word-index slice of the address matters; the base is decoded upstream.
  assign aw_idx           = S_AXI_AWADDR[BYTE_LSB +: IDX_W];
  assign ar_idx           = S_AXI_ARADDR[BYTE_LSB +: IDX_W];
  assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  assign w_idx_next = (w_burst == 2'b00) ? w_idx : w_idx + IDX_W'(1);
  assign r_idx_next = (r_burst == 2'b00) ? r_idx : r_idx + IDX_W'(1);
  assign w_fire     = S_AXI_WVALID && S_AXI_WREADY;
  assign w_final    = (w_cnt == w_len);
  assign wlast_bad  = (S_AXI_WLAST != w_final);
  assign S_AXI_RRESP = 2'b00;

  // Memory array carries no reset so beats survive an interrupted burst.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      w_idx         <= '0;
      w_len         <= 8'd0;
      w_cnt         <= 8'd0;
      w_burst       <= 2'b00;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            w_idx         <= aw_idx;
            w_len         <= S_AXI_AWLEN;
            w_burst       <= S_AXI_AWBURST;
            w_cnt         <= 8'd0;
            w_err         <= 1'b0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= w_idx_next;
            w_cnt <= w_cnt + 8'd1;
            w_err <= w_err | wlast_bad;
            // AWLEN alone ends the burst; a misplaced WLAST only flags SLVERR.
            if (w_final) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= (w_err || wlast_bad) ? 2'b10 : 2'b00;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: begin
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // RDATA is loaded one beat ahead, so a same-cycle write to that word is not seen.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RDATA   <= '0;
      r_idx         <= '0;
      r_len         <= 8'd0;
      r_cnt         <= 8'd0;
      r_burst       <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= mem[ar_idx];
            S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
            r_idx         <= ar_idx;
            r_len         <= S_AXI_ARLEN;
            r_burst       <= S_AXI_ARBURST;
            r_cnt         <= 8'd0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_ARREADY <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_idx       <= r_idx_next;
              r_cnt       <= r_cnt + 8'd1;
              S_AXI_RDATA <= mem[r_idx_next];
              S_AXI_RLAST <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: begin
          r_state <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_full_slave_ram.md
AXI_FULL_SLAVE_RAM -- requirements
Module: axi_full_slave_ram

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 64, data width; legal values are 32 and 64.
REQ-003 SHALL have parameter C_MEM_DEPTH, default 256, number of data-width words; must be a power of two.
REQ-004 SHALL have ports (name  direction  width  meaning), one clock, asynchronous active-low reset:
- S_AXI_ACLK  in  1  clock, all logic on rising edge
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  ADDR  write burst start address
- S_AXI_AWLEN  in  8  write beats minus 1
- S_AXI_AWBURST  in  2  burst type
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  DATA  write data
- S_AXI_WSTRB  in  DATA/8  byte enables
- S_AXI_WLAST  in  1  last write beat marker
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARADDR  in  ADDR  read burst start address
- S_AXI_ARLEN  in  8  read beats minus 1
- S_AXI_ARBURST  in  2  burst type
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RDATA  out  DATA  read data
- S_AXI_RRESP  out  2  read response, always 2'b00
- S_AXI_RLAST  out  1  last read beat marker
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
REQ-005 SHALL NOT provide ID, SIZE, LOCK, CACHE, PROT, QOS or USER ports. Integration ties the master's BID/RID inputs to 0. Every transfer is full data width.

Function
REQ-006 Word index SHALL be addr[log2(DATA/8)+log2(C_MEM_DEPTH)-1 : log2(DATA/8)]. Upper address bits are ignored, and the base address is decoded upstream.
REQ-007 Burst beat count SHALL be AxLEN+1 (1..256).
- AxBURST 2'b00 (FIXED) holds the index for every beat.
- All other AxBURST values increment the index by 1 per beat, wrapping modulo C_MEM_DEPTH.
REQ-008 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
- W_IDLE: AWREADY=1. On AW handshake, latch index, AWLEN and burst type; go to W_DATA.
- W_DATA: WREADY=1. Each W handshake writes the enabled bytes (per WSTRB) to mem[index] and advances the index.
- On the (AWLEN+1)th beat, go to W_RESP.
- W_RESP: BVALID=1 until the B handshake, then W_IDLE; AWREADY returns 1 the cycle after the B handshake.
REQ-009 BRESP SHALL be 2'b00, or 2'b10 (SLVERR) if any beat had WLAST mismatching "is final beat". Burst length is governed by AWLEN only, and all beats are written regardless of BRESP.
REQ-010 Read FSM SHALL have states R_IDLE and R_DATA.
- R_IDLE: ARREADY=1. On AR handshake, latch index, ARLEN and burst type; RVALID=1 from the next cycle.
- R_DATA: RDATA=mem[current index] and RLAST=1 on the (ARLEN+1)th beat.
- Each R handshake advances the index, with no bubble between beats.
- The R handshake with RLAST=1 returns the FSM to R_IDLE.
REQ-011 With RVALID=1 and RREADY=0, RDATA, RLAST and RVALID SHALL hold stable.
REQ-012 Read and write FSMs SHALL operate concurrently and independently. If a read beat and a write hit the same word in the same cycle, the read beat returns pre-write data.
REQ-013 Handshakes SHALL occur only when both VALID and READY are high at a rising edge. No output may depend combinationally on an input VALID or READY.

Reset
REQ-014 S_AXI_ARESETN low SHALL immediately force both FSMs to idle and drive all outputs low: AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RDATA=0.
REQ-015 AWREADY and ARREADY SHALL rise on the first clock edge after reset deassertion.
REQ-016 Memory contents SHALL NOT be reset. Beats written before a mid-burst reset are retained, and no B or R response is issued for the interrupted burst.

Verification
REQ-017 Reset: assert ARESETN low mid read burst -> RVALID=0 and ARREADY=0 without a clock edge; ARREADY=1 one edge after release.
REQ-018 Write then read: AWADDR=0x40000000, AWLEN=16, WDATA 1..17, WLAST on beat 17 -> BVALID one cycle after beat 17 with BRESP=00. Read at the same address with ARLEN=16 -> RDATA 1..17, RLAST only on beat 17.
REQ-019 Backpressure: ARLEN=3, RREADY toggled 1,0,0,1,... -> each RDATA held while RREADY=0, four distinct beats, no beat lost or duplicated. BREADY held 0 for 5 cycles -> BVALID held, AWREADY=0 throughout.
REQ-020 WLAST error: AWLEN=3 with WLAST on beat 2 -> four beats accepted, all written, BRESP=2'b10.
REQ-021 Wrap and strobe (64-bit, depth 256):
- AWADDR offset 0x7F8, AWLEN=1 -> words 255 and 0 written.
- WSTRB=0x0F over 0xFFFFFFFF_FFFFFFFF, data 0 -> word reads 0xFFFFFFFF_00000000.
